ram_stream_reader: RTL and testbench

- Owns an inferred simple dual-port RAM with a direct upstream write port.
- On a start command it reads a contiguous address window and streams the words out on a valid/ready interface with last-beat marking.
- While streaming, tracks the maximum value and its address, and reports both when the dump completes.
- Acts as the reader/streamer counterpart to the team's RAM fill-and-scan blocks, handing RAM contents to downstream consumers.

---
 rtl/ram_stream_reader_if.sv | 44 ++++
 rtl/ram_stream_reader.sv | 175 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Bundle between ram_stream_reader and its host: RAM write port, dump command, output beat stream, result.
// master = the reader itself (drives the stream and status); slave = host/consumer side.
interface ram_stream_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   len;
  logic              busy;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;
  logic              m_last;

  logic              done;
  logic [DATA_W-1:0] max_val;
  logic [ADDR_W-1:0] max_addr;
  logic              max_valid;

  modport master (
    input  wr_en, wr_addr, wr_data,
    input  start, start_addr, len,
    output busy,
    output m_valid, m_data, m_addr, m_last,
    input  m_ready,
    output done, max_val, max_addr, max_valid
  );

  modport slave (
    output wr_en, wr_addr, wr_data,
    output start, start_addr, len,
    input  busy,
    input  m_valid, m_data, m_addr, m_last,
    output m_ready,
    input  done, max_val, max_addr, max_valid
  );
endinterface

// File: rtl/ram_stream_reader.sv
// RAM with a free-running write port; on start, streams a wrapped address window out through a
// 2-entry skid buffer (1 word/cycle, first beat 2 cycles after start) and reports the stream maximum.
module ram_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_stream_reader_if.master  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] ram_q;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [1:0]        cnt_q, cnt_d;

  logic              rd_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_last_q;

  beat_t             buf_q [2];
  beat_t             buf_d [2];
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  beat_t             incoming;

  logic              done_q, done_d;
  logic [DATA_W-1:0] max_val_q, max_val_d;
  logic [ADDR_W-1:0] max_addr_q, max_addr_d;
  logic              max_vld_q, max_vld_d;

  logic              pop;
  logic              issue;

  assign pop   = (buf_cnt_q != 2'd0) && bus.m_ready;
  // Outstanding words (in the RAM stage or the buffer) may not exceed 2; a same-cycle accept frees a slot.
  assign issue = (state_q == S_RUN) && ((cnt_q < 2'd2) || pop);

  // Nonblocking write plus registered read gives old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem_q[bus.wr_addr] <= bus.wr_data;
    if (issue)     ram_q <= mem_q[addr_q];
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    max_val_d  = max_val_q;
    max_addr_d = max_addr_q;
    max_vld_d  = max_vld_q;

    if (pop && (buf_q[0].dat >= max_val_q)) begin
      max_val_d  = buf_q[0].dat;
      max_addr_d = buf_q[0].addr;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          addr_d     = bus.start_addr;
          rem_d      = bus.len;
          max_val_d  = '0;
          max_addr_d = '0;
          max_vld_d  = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + ADDR_ONE;
          rem_d  = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && buf_q[0].last) begin
          done_d    = 1'b1;
          max_vld_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = cnt_q + {1'b0, issue} - {1'b0, pop};

  assign incoming.dat  = ram_q;
  assign incoming.addr = rd_addr_q;
  assign incoming.last = rd_last_q;

  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    if (pop) begin
      buf_d[0]  = buf_q[1];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (rd_vld_q) begin
      if (buf_cnt_d == 2'd0) buf_d[0] = incoming;
      else                   buf_d[1] = incoming;
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= '0;
      rd_last_q  <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      buf_cnt_q  <= '0;
      done_q     <= 1'b0;
      max_val_q  <= '0;
      max_addr_q <= '0;
      max_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      rd_vld_q   <= issue;
      rd_addr_q  <= addr_q;
      rd_last_q  <= issue && (rem_q == LEN_ONE);
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      done_q     <= done_d;
      max_val_q  <= max_val_d;
      max_addr_q <= max_addr_d;
      max_vld_q  <= max_vld_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.m_valid   = (buf_cnt_q != 2'd0);
  assign bus.m_data    = buf_q[0].dat;
  assign bus.m_addr    = buf_q[0].addr;
  assign bus.m_last    = buf_q[0].last;
  assign bus.done      = done_q;
  assign bus.max_val   = max_val_q;
  assign bus.max_addr  = max_addr_q;
  assign bus.max_valid = max_vld_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !((buf_cnt_q == 2'd2) && rd_vld_q && !pop));

  a_hold_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data) && $stable(bus.m_addr)
                                       && $stable(bus.m_last)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: expected beats queued at stimulus time, compared per test.
module tb_ram_stream_reader;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] a;
    logic       l;
  } beat_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  beat_t exp_q[$];
  beat_t got_q[$];
  int    first_vld_cyc, done_cyc, last_cyc, done_cnt, stall_bad;
  bit    busy_seen;

  ram_stream_reader_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  ram_stream_reader #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] a, input logic [8:0] n);
    bus.start = 1'b1; bus.start_addr = a; bus.len = n;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Cycle c is the cycle following edge T+c, where T is the edge that sampled start.
  // stop: 0 = stop on done, >0 = stop after that many beats, <0 = run the full budget.
  task automatic collect(input int budget, input int mode, input int stop, input int inj_cyc,
                         input logic [7:0] inj_addr, input logic [8:0] inj_len);
    bit pv, pr;
    beat_t pb, cur;
    got_q.delete();
    first_vld_cyc = -1; done_cyc = -1; last_cyc = -1; done_cnt = 0; stall_bad = 0;
    busy_seen = 1'b0; pv = 1'b0; pr = 1'b0; pb = '0;
    for (int c = 0; c < budget; c++) begin
      bus.m_ready = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      if (c == inj_cyc) begin
        bus.start = 1'b1; bus.start_addr = inj_addr; bus.len = inj_len;
      end
      @(negedge clk);
      cur = '{d: bus.m_data, a: bus.m_addr, l: bus.m_last};
      if (bus.busy) busy_seen = 1'b1;
      if (pv && !pr && (!bus.m_valid || cur !== pb)) stall_bad++;
      if (bus.m_valid && first_vld_cyc < 0) first_vld_cyc = c;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back(cur);
        if (bus.m_last) last_cyc = c;
      end
      pv = bus.m_valid; pr = bus.m_ready; pb = cur;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if ((stop == 0 && bus.done) || (stop > 0 && got_q.size() >= stop)) break;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.wr_en = 1'b0;
    end
  endtask

  function automatic void model_max(output logic [7:0] mv, output logic [7:0] ma);
    mv = 8'd0; ma = 8'd0;
    foreach (exp_q[i]) if (exp_q[i].d >= mv) begin mv = exp_q[i].d; ma = exp_q[i].a; end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.start = 0; bus.start_addr = 0; bus.len = 0; bus.m_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.busy, bus.m_valid, bus.m_data, bus.m_addr, bus.m_last, bus.done,
         bus.max_val, bus.max_addr, bus.max_valid} !== 29'd0) begin
      bad++;
      $display("FAIL reset_state busy=%b vld=%b dat=%h addr=%h last=%b done=%b max=%h/%h mv=%b required all 0",
               bus.busy, bus.m_valid, bus.m_data, bus.m_addr, bus.m_last, bus.done,
               bus.max_val, bus.max_addr, bus.max_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input int mode, input string nm);
    beat_t e, g;
    logic [7:0] mv, ma;
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      if (mode == 0) wr(8'(i), 8'(i % 9));
      exp_q.push_back('{d: 8'(i % 9), a: 8'(i), l: (i == 99)});
    end
    model_max(mv, ma);
    do_start(8'd0, 9'd100);
    collect(600, mode, 0, -1, 8'd0, 9'd0);
    total++;
    if (got_q.size() != 100) begin bad++; $display("FAIL %s_count got=%0d req=100", nm, got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL %s_beat got=%h/%h/%b req=%h/%h/%b", nm, g.d, g.a, g.l, e.d, e.a, e.l);
      end
    end
    total++;
    if (done_cnt != 1) begin bad++; $display("FAIL %s_done got=%0d pulses req=1", nm, done_cnt); end
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL %s_stall_hold got=%0d changes req=0", nm, stall_bad); end
    if (mode == 0) begin
      total++;
      if (first_vld_cyc != 2) begin bad++; $display("FAIL %s_first_latency got=%0d req=2", nm, first_vld_cyc); end
      total++;
      if (last_cyc != 101) begin bad++; $display("FAIL %s_last_latency got=%0d req=101", nm, last_cyc); end
      total++;
      if (done_cyc != 102) begin bad++; $display("FAIL %s_done_latency got=%0d req=102", nm, done_cyc); end
    end
    total++;
    if ({bus.max_val, bus.max_addr, bus.max_valid} !== {mv, ma, 1'b1}) begin
      bad++;
      $display("FAIL %s_max got=%h@%h v=%b req=%h@%h v=1", nm, bus.max_val, bus.max_addr, bus.max_valid, mv, ma);
    end
  endtask

  task automatic test_len0_and_busy_start();
    beat_t e, g;
    do_start(8'd0, 9'd0);
    collect(10, 0, -1, -1, 8'd0, 9'd0);
    total++;
    if (busy_seen || got_q.size() != 0 || done_cnt != 0) begin
      bad++;
      $display("FAIL len0_ignored busy=%b beats=%0d done=%0d req 0/0/0", busy_seen, got_q.size(), done_cnt);
    end
    exp_q.delete();
    for (int i = 0; i < 100; i++) exp_q.push_back('{d: 8'(i % 9), a: 8'(i), l: (i == 99)});
    do_start(8'd0, 9'd100);
    collect(300, 0, 0, 10, 8'd50, 9'd5);
    total++;
    if (got_q.size() != 100 || done_cyc != 102) begin
      bad++;
      $display("FAIL busy_start_shape beats=%0d done_cyc=%0d req 100/102", got_q.size(), done_cyc);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL busy_start_beat got=%h/%h/%b req=%h/%h/%b", g.d, g.a, g.l, e.d, e.a, e.l);
      end
    end
    total++;
    if ({bus.max_val, bus.max_addr} !== 16'h0862) begin
      bad++; $display("FAIL busy_start_max got=%h@%h req=08@62", bus.max_val, bus.max_addr);
    end
  endtask

  task automatic test_wrap();
    beat_t e, g;
    logic [7:0] mv, ma;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      wr(8'(250 + i), 8'(i + 1));
      exp_q.push_back('{d: 8'(i + 1), a: 8'(250 + i), l: (i == 9)});
    end
    model_max(mv, ma);
    do_start(8'd250, 9'd10);
    collect(100, 0, 0, -1, 8'd0, 9'd0);
    total++;
    if (got_q.size() != 10 || done_cnt != 1) begin
      bad++; $display("FAIL wrap_shape beats=%0d done=%0d req 10/1", got_q.size(), done_cnt);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL wrap_beat got=%h/%h/%b req=%h/%h/%b", g.d, g.a, g.l, e.d, e.a, e.l);
      end
    end
    total++;
    if ({bus.max_val, bus.max_addr, bus.max_valid} !== {mv, ma, 1'b1}) begin
      bad++; $display("FAIL wrap_max got=%h@%h req=%h@%h", bus.max_val, bus.max_addr, mv, ma);
    end
  endtask

  task automatic test_read_during_write();
    wr(8'd5, 8'h11);
    do_start(8'd5, 9'd1);
    bus.wr_en = 1'b1; bus.wr_addr = 8'd5; bus.wr_data = 8'h22;
    collect(20, 0, 0, -1, 8'd0, 9'd0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== beat_t'({8'h11, 8'h05, 1'b1})) begin
      bad++;
      $display("FAIL rdw_old_data beats=%0d first=%h req 1 beat 11/05/1", got_q.size(),
               (got_q.size() > 0) ? got_q[0].d : 8'hxx);
    end
    do_start(8'd5, 9'd1);
    collect(20, 0, 0, -1, 8'd0, 9'd0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== beat_t'({8'h22, 8'h05, 1'b1})) begin
      bad++;
      $display("FAIL rdw_new_data beats=%0d first=%h req 1 beat 22/05/1", got_q.size(),
               (got_q.size() > 0) ? got_q[0].d : 8'hxx);
    end
  endtask

  task automatic test_reset_mid_dump();
    beat_t e, g;
    logic [7:0] mv, ma;
    for (int i = 0; i < 20; i++) wr(8'(100 + i), 8'((i * 7 + 3) & 8'hff));
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back('{d: 8'(i * 7 + 3), a: 8'(100 + i), l: (i == 19)});
    do_start(8'd100, 9'd20);
    collect(50, 0, 3, -1, 8'd0, 9'd0);
    total++;
    if (got_q.size() != 3) begin bad++; $display("FAIL rst_mid_pre_beats got=%0d req=3", got_q.size()); end
    while (got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin
        bad++; $display("FAIL rst_mid_pre_beat got=%h/%h req=%h/%h", g.d, g.a, e.d, e.a);
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.m_valid, bus.busy, bus.done, bus.max_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid_async vld=%b busy=%b done=%b maxv=%b req all 0",
               bus.m_valid, bus.busy, bus.done, bus.max_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    for (int i = 10; i < 16; i++) exp_q.push_back('{d: 8'(i * 7 + 3), a: 8'(100 + i), l: (i == 15)});
    model_max(mv, ma);
    do_start(8'd110, 9'd6);
    collect(60, 0, 0, -1, 8'd0, 9'd0);
    total++;
    if (got_q.size() != 6 || done_cnt != 1) begin
      bad++; $display("FAIL rst_mid_after_shape beats=%0d done=%0d req 6/1", got_q.size(), done_cnt);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); total++;
      if (g !== e) begin
        bad++;
        $display("FAIL rst_mid_after_beat got=%h/%h/%b req=%h/%h/%b", g.d, g.a, g.l, e.d, e.a, e.l);
      end
    end
    total++;
    if ({bus.max_val, bus.max_addr} !== {mv, ma}) begin
      bad++; $display("FAIL rst_mid_after_max got=%h@%h req=%h@%h", bus.max_val, bus.max_addr, mv, ma);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "backpressure");
    test_len0_and_busy_start();
    test_wrap();
    test_read_during_write();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
